// File: rtl/seq_scan_pkg.sv
// Shared types and default sizes for the sequential run-length scanner.
package seq_scan_pkg;

    localparam int DEF_WORD_W = 16;
    localparam int DEF_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

endpackage

// File: rtl/seq_scan_run_detector.sv
// Saturating run-of-ones counter with a registered threshold hit flag.
module run_detector
    import seq_scan_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             scan_bit,
    input  logic [CNT_W-1:0] thr,
    output logic             hit
);

    localparam logic [CNT_W-1:0] RUN_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] RUN_ONE = CNT_W'(1);

    logic [CNT_W-1:0] run;
    logic [CNT_W-1:0] run_nxt;
    logic             hit_nxt;

    // The hit compare uses the run after the current bit has been counted.
    always_comb begin
        run_nxt = '0;
        if (scan_bit) begin
            run_nxt = (run == RUN_MAX) ? run : run + RUN_ONE;
        end
        hit_nxt = (thr != '0) && (run_nxt >= thr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run <= '0;
            hit <= 1'b0;
        end else if (clr) begin
            run <= '0;
            hit <= 1'b0;
        end else if (en) begin
            run <= run_nxt;
            hit <= hit_nxt;
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Accepts one word plus threshold, scans it MSB first one bit per cycle and
// reports how many positions closed a run of ones at or above the threshold.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WORD_W-1:0]           in_word,
    input  logic [CNT_W-1:0]            in_thr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(WORD_W):0]     out_hits,
    output logic [$clog2(WORD_W)-1:0]   out_first,
    output logic                        out_found,
    output logic                        busy,
    output logic [1:0]                  dbg_state
);

    localparam int IDX_W   = $clog2(WORD_W) + 1;
    localparam int FIRST_W = $clog2(WORD_W);
    localparam logic [IDX_W-1:0] IDX_END = IDX_W'(WORD_W);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high. in_ready/out_valid depend only on state, never on the peer's
    // valid/ready, and out_* hold steady while out_valid waits for out_ready.

    state_t               state;
    state_t               state_nxt;
    logic [WORD_W-1:0]    word_q;
    logic [CNT_W-1:0]     thr_q;
    logic [IDX_W-1:0]     index;
    logic [IDX_W-1:0]     prev_idx;
    logic [IDX_W-1:0]     hits_q;
    logic [FIRST_W-1:0]   first_q;
    logic                 found_q;
    logic                 accept;
    logic                 scan_en;
    logic                 hit_valid;
    logic                 hit;

    assign accept    = in_valid && in_ready;
    assign scan_en   = (state == SHIFT) && (index != IDX_END);
    // The detector's hit is registered, so it describes the bit at index-1.
    assign hit_valid = (state == SHIFT) && (index != '0);
    assign prev_idx  = index - IDX_ONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (index == IDX_END) state_nxt = REPORT;
            REPORT:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == REPORT);
        busy      = (state == SHIFT) || (state == REPORT);
        dbg_state = state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q  <= '0;
            thr_q   <= '0;
            index   <= '0;
            hits_q  <= '0;
            first_q <= '0;
            found_q <= 1'b0;
        end else if (accept) begin
            word_q  <= in_word;
            thr_q   <= in_thr;
            index   <= '0;
            hits_q  <= '0;
            first_q <= '0;
            found_q <= 1'b0;
        end else if (state == SHIFT) begin
            if (scan_en) begin
                index  <= index + IDX_ONE;
                word_q <= {word_q[WORD_W-2:0], 1'b0};
            end
            if (hit_valid && hit) begin
                hits_q <= hits_q + IDX_ONE;
                if (!found_q) begin
                    found_q <= 1'b1;
                    first_q <= prev_idx[FIRST_W-1:0];
                end
            end
        end
    end

    run_detector #(
        .CNT_W (CNT_W)
    ) u_run_detector (
        .clk      (clk),
        .reset    (reset),
        .clr      (accept),
        .en       (scan_en),
        .scan_bit (word_q[WORD_W-1]),
        .thr      (thr_q),
        .hit      (hit)
    );

    assign out_hits  = hits_q;
    assign out_first = first_q;
    assign out_found = found_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl: directed vectors, back-pressure,
// mid-scan reset and randomized words against a bit-level reference model.
module tb_seq_scan_ctrl;

    localparam int W = 10; // {hits[4:0], first[3:0], found}

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_word;
    logic [3:0]  in_thr;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_hits;
    logic [3:0]  out_first;
    logic        out_found;
    logic        busy;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    seq_scan_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .in_thr    (in_thr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hits  (out_hits),
        .out_first (out_first),
        .out_found (out_found),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: walk the word MSB first, track the run of ones with saturation.
    function automatic logic [W-1:0] model(input logic [15:0] w, input logic [3:0] t);
        int run   = 0;
        int hits  = 0;
        int first = 0;
        bit found = 0;
        for (int i = 0; i < 16; i++) begin
            if (w[15-i]) run = (run < 15) ? run + 1 : 15;
            else         run = 0;
            if (t != 0 && run >= int'(t)) begin
                hits++;
                if (!found) begin
                    found = 1;
                    first = i;
                end
            end
        end
        return {5'(hits), 4'(first), found};
    endfunction

    // Offers one word, waits for the result, holds it for `hold` cycles.
    task automatic drive_scan(input logic [15:0] w, input logic [3:0] t, input int hold,
                              input bit noise, output int lat, output logic [W-1:0] res,
                              output bit stable, output bit quiet);
        quiet  = 1;
        stable = 1;
        lat    = 0;
        in_word  = w;
        in_thr   = t;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_word  = 16'($urandom);
        in_thr   = 4'($urandom);
        while (out_valid !== 1'b1 && lat < 40) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) quiet = 0;
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                in_word  = 16'($urandom);
                in_thr   = 4'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        res = {out_hits, out_first, out_found};
        repeat (hold) begin
            @(posedge clk); #1;
            if ({out_hits, out_first, out_found} !== res || out_valid !== 1'b1 || in_ready !== 1'b0)
                stable = 0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) stable = 0;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_word   = '0;
        in_thr    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, busy, dbg_state} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0000", {out_valid, busy, dbg_state});
        end
        checks++;
        if ({out_hits, out_first, out_found} !== 10'd0) begin
            failures++;
            $display("FAIL reset_results got=%h exp=0", {out_hits, out_first, out_found});
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [15:0] words[5] = '{16'hFFFF, 16'b0111_0111_0000_1111, 16'h0000, 16'hFFFF, 16'hFFFF};
        logic [3:0]  thrs[5]  = '{4'd3, 4'd3, 4'd1, 4'd0, 4'd15};
        logic [W-1:0] spec_res[5] = '{{5'd14, 4'd2, 1'b1}, {5'd4, 4'd3, 1'b1}, 10'd0, 10'd0,
                                      {5'd2, 4'd14, 1'b1}};
        int lat;
        logic [W-1:0] res;
        logic [W-1:0] exp_v;
        bit stable;
        bit quiet;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(model(words[i], thrs[i]));
            drive_scan(words[i], thrs[i], 0, 1'b0, lat, res, stable, quiet);
            exp_v = exp_q.pop_front();
            checks++;
            if (res !== exp_v || res !== spec_res[i]) begin
                failures++;
                $display("FAIL directed_result[%0d] got=%h exp=%h", i, res, spec_res[i]);
            end
            checks++;
            if (lat != 17) begin
                failures++;
                $display("FAIL directed_latency[%0d] got=%0d exp=17", i, lat);
            end
            checks++;
            if (!quiet || !stable) begin
                failures++;
                $display("FAIL directed_handshake[%0d] quiet=%0d stable=%0d exp 1/1", i, quiet, stable);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [W-1:0] res;
        logic [W-1:0] exp_v;
        bit stable;
        bit quiet;
        logic [15:0] w;
        logic [3:0]  t;
        for (int i = 0; i < 3; i++) begin
            w = 16'($urandom);
            t = 4'($urandom_range(1, 4));
            exp_q.push_back(model(w, t));
            drive_scan(w, t, 5, 1'b1, lat, res, stable, quiet);
            exp_v = exp_q.pop_front();
            checks++;
            if (res !== exp_v) begin
                failures++;
                $display("FAIL bp_result[%0d] got=%h exp=%h", i, res, exp_v);
            end
            checks++;
            if (!stable || !quiet || lat != 17) begin
                failures++;
                $display("FAIL bp_hold[%0d] stable=%0d quiet=%0d lat=%0d exp 1/1/17", i, stable, quiet, lat);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [W-1:0] res;
        logic [W-1:0] exp_v;
        bit stable;
        bit quiet;
        bit saw_valid = 0;
        in_word  = 16'hFFFF;
        in_thr   = 4'd1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({out_valid, busy, dbg_state, in_ready} !== 5'b00001) begin
            failures++;
            $display("FAIL midreset_ctrl got=%b exp=00001", {out_valid, busy, dbg_state, in_ready});
        end
        checks++;
        if ({out_hits, out_first, out_found} !== 10'd0) begin
            failures++;
            $display("FAIL midreset_results got=%h exp=0", {out_hits, out_first, out_found});
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (25) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) saw_valid = 1;
        end
        checks++;
        if (saw_valid) begin
            failures++;
            $display("FAIL midreset_no_output got=1 exp=0");
        end
        exp_q.push_back(model(16'b0111_0111_0000_1111, 4'd3));
        drive_scan(16'b0111_0111_0000_1111, 4'd3, 1, 1'b0, lat, res, stable, quiet);
        exp_v = exp_q.pop_front();
        checks++;
        if (res !== exp_v || lat != 17) begin
            failures++;
            $display("FAIL midreset_next got=%h lat=%0d exp=%h lat=17", res, lat, exp_v);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [W-1:0] res;
        logic [W-1:0] exp_v;
        bit stable;
        bit quiet;
        logic [15:0] w;
        logic [3:0]  t;
        for (int i = 0; i < 30; i++) begin
            w = 16'($urandom);
            if (i % 3 == 0) w = w | 16'hF0F0;
            t = 4'($urandom_range(0, 15));
            exp_q.push_back(model(w, t));
            drive_scan(w, t, $urandom_range(0, 3), 1'($urandom_range(0, 1)), lat, res, stable, quiet);
            exp_v = exp_q.pop_front();
            checks++;
            if (res !== exp_v || lat != 17 || !stable || !quiet) begin
                failures++;
                $display("FAIL random[%0d] w=%h t=%0d got=%h exp=%h lat=%0d stable=%0d quiet=%0d",
                         i, w, t, res, exp_v, lat, stable, quiet);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 Parameter WORD_W, default 16: bits per scanned word.
REQ-002 Parameter CNT_W, default 4: width of threshold and run counter.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  word/threshold offered.
REQ-006 in_ready  output  1  block accepts a word this cycle.
REQ-007 in_word  input  WORD_W  bit stream, scanned MSB first.
REQ-008 in_thr  input  CNT_W  required run length of consecutive 1s.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 out_hits  output  $clog2(WORD_W)+1  count of bit positions where run >= threshold.
REQ-012 out_first  output  $clog2(WORD_W)  scan index (0 = MSB) of first hit.
REQ-013 out_found  output  1  at least one hit in the word.
REQ-014 busy  output  1  high in SHIFT or REPORT.

Function
REQ-015 FSM states IDLE, SHIFT, REPORT; in_ready = (state==IDLE); out_valid = (state==REPORT).
REQ-016 IDLE: in_valid&in_ready captures in_word and in_thr, clears run counter, index, hits, found, first; next state SHIFT.
REQ-017 SHIFT: one bit per cycle, index 0..WORD_W-1, bit = captured word[WORD_W-1-index].
REQ-018 Run counter: bit 1 -> run+1, saturating at 2^CNT_W-1; bit 0 -> run 0.
REQ-019 Hit at an index when thr != 0 and the updated run (including the current bit) >= thr.
REQ-020 On each hit hits increments; on first hit found=1 and first=index.
REQ-021 After index WORD_W-1 is processed, next state REPORT.
REQ-022 REPORT: out_hits/out_first/out_found held stable until out_valid&out_ready; next state IDLE.
REQ-023 Latency: acceptance at edge k -> out_valid high from edge k+WORD_W+1.
REQ-024 thr==0 -> hits=0, found=0, first=0.
REQ-025 No hit -> found=0, first=0.
REQ-026 in_valid outside IDLE is ignored; no words are queued.
REQ-027 Input word and threshold changes after acceptance have no effect on the current scan.
REQ-028 Run state does not carry between words.

Reset
REQ-029 While reset is low: state IDLE; run, index, hits, first, found and captured registers are 0; out_valid=0; busy=0.
REQ-030 After reset is released, in_ready=1.
REQ-031 Reset asserted in SHIFT or REPORT aborts the scan; no out_valid is produced for that word.

Structure
REQ-032 Shared package seq_scan_pkg SHALL hold the state enum (IDLE, SHIFT, REPORT) and the default WORD_W and CNT_W constants.
REQ-033 The run counter and hit compare SHALL live in a sub-module run_detector (inputs: clk, reset, clr, en, bit, thr; output: hit).
REQ-034 seq_scan_ctrl SHALL contain the FSM, index counter, handshakes and result registers.

Verification
REQ-035 Word 16'hFFFF, thr 3 -> hits 14, first 2, found 1; out_valid exactly 17 cycles after acceptance.
REQ-036 Word 16'b0111_0111_0000_1111, thr 3 -> hits 4, first 3, found 1.
REQ-037 Word 16'h0000, thr 1, and word 16'hFFFF, thr 0 -> hits 0, found 0, first 0.
REQ-038 Hold out_ready low for 5 cycles in REPORT -> results stable, in_ready 0; in_valid pulses during SHIFT are ignored.
REQ-039 Assert reset at index 8 of SHIFT -> immediate IDLE, outputs 0, no out_valid; the next word then scans correctly.
REQ-040 Word 16'hFFFF, thr 15 -> saturation: hits 2 (indices 14, 15), first 14.
